// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser: pays out change one coin at a time from a two-tube hopper.
// Ports: clk, rst (async active-low); change/change_vld request; coin_drop ack;
//        fault_clr; refill_5/refill_10; eject_5/eject_10 strobes; busy, done,
//        fault, fault_code[1:0]; stock_5/stock_10 tube counts.
module vm_change_dispenser #(
    parameter int EJECT_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int STOCK_W        = 4,
    parameter int INIT_5         = 4,
    parameter int INIT_10        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         change,
    input  logic               change_vld,
    input  logic               coin_drop,
    input  logic               fault_clr,
    input  logic               refill_5,
    input  logic               refill_10,
    output logic               eject_5,
    output logic               eject_10,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [STOCK_W-1:0] stock_5,
    output logic [STOCK_W-1:0] stock_10
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_EJECT,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    localparam int CNT_MAX =
        (EJECT_CYCLES > TIMEOUT_CYCLES) ? EJECT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [STOCK_W-1:0] SMAX = {STOCK_W{1'b1}};

    state_t        state;
    logic [1:0]    rem;
    logic          sel10;
    logic [CW-1:0] cnt;
    logic          dec5;
    logic          dec10;

    // A coin is consumed from its tube in the cycle its drop is acknowledged.
    always_comb begin
        dec5  = 1'b0;
        dec10 = 1'b0;
        if (state == S_WAIT && coin_drop) begin
            dec5  = !sel10;
            dec10 = sel10;
        end
    end

    // Refill and consume in the same cycle cancel out.
    function automatic logic [STOCK_W-1:0] nxt_stock(
        input logic [STOCK_W-1:0] cur,
        input logic               inc,
        input logic               dec
    );
        if (inc && !dec)
            return (cur == SMAX) ? cur : cur + 1'b1;
        else if (dec && !inc && cur != '0)
            return cur - 1'b1;
        else
            return cur;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rem        <= 2'b00;
            sel10      <= 1'b0;
            cnt        <= '0;
            eject_5    <= 1'b0;
            eject_10   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            stock_5    <= STOCK_W'(INIT_5);
            stock_10   <= STOCK_W'(INIT_10);
        end else begin
            stock_5  <= nxt_stock(stock_5, refill_5, dec5);
            stock_10 <= nxt_stock(stock_10, refill_10, dec10);
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (change_vld) begin
                        if (change != 2'b00) begin
                            rem   <= change;
                            busy  <= 1'b1;
                            state <= S_CHECK;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    cnt <= '0;
                    if (rem == 2'b00) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (rem[1] && stock_10 != '0) begin
                        sel10    <= 1'b1;
                        eject_10 <= 1'b1;
                        state    <= S_EJECT;
                    end else if (stock_5 != '0) begin
                        // also covers paying a 10 as 5+5 when the 10 tube is empty
                        sel10   <= 1'b0;
                        eject_5 <= 1'b1;
                        state   <= S_EJECT;
                    end else begin
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                        state      <= S_FAULT;
                    end
                end
                S_EJECT: begin
                    if (cnt == CW'(EJECT_CYCLES - 1)) begin
                        eject_5  <= 1'b0;
                        eject_10 <= 1'b0;
                        cnt      <= '0;
                        state    <= S_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (coin_drop) begin
                        rem   <= rem - (sel10 ? 2'd2 : 2'd1);
                        state <= S_CHECK;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        fault      <= 1'b1;
                        fault_code <= 2'b01;
                        state      <= S_FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                        rem        <= 2'b00;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// tb_vm_change_dispenser: directed bench for vm_change_dispenser.
// Drives payout requests, acks coins, and checks strobes, stock and faults.
module tb_vm_change_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] change = 2'b00;
    logic       change_vld = 1'b0;
    logic       coin_drop = 1'b0;
    logic       fault_clr = 1'b0;
    logic       refill_5 = 1'b0;
    logic       refill_10 = 1'b0;
    logic       eject_5;
    logic       eject_10;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;
    logic [3:0] stock_5;
    logic [3:0] stock_10;

    int checks = 0;
    int errors = 0;
    int n5, n10, ndone, lat, wcyc, seq, overlap;
    bit saw_fault;
    bit timed_out;

    vm_change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .change     (change),
        .change_vld (change_vld),
        .coin_drop  (coin_drop),
        .fault_clr  (fault_clr),
        .refill_5   (refill_5),
        .refill_10  (refill_10),
        .eject_5    (eject_5),
        .eject_10   (eject_10),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .stock_5    (stock_5),
        .stock_10   (stock_10)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    // Issue one request and follow it until done or fault, acking each coin
    // one cycle after its strobe ends when ack is set.
    task automatic pay(input logic [1:0] amt, input bit ack, input bit rf);
        bit prev_e;
        bit inwait;
        int cyc;
        n5 = 0; n10 = 0; ndone = 0; lat = 0; wcyc = 0;
        seq = 0; overlap = 0; saw_fault = 0; timed_out = 1;
        prev_e = 0; inwait = 0;
        @(negedge clk);
        change = amt;
        change_vld = 1'b1;
        @(negedge clk);
        change_vld = 1'b0;
        change = 2'b00;
        for (cyc = 1; cyc <= 60; cyc++) begin
            coin_drop = 1'b0;
            refill_5 = 1'b0;
            if (eject_5 && eject_10) overlap++;
            if (eject_5) n5++;
            if (eject_10) n10++;
            if (eject_5 && !prev_e) seq = seq * 100 + 5;
            if (eject_10 && !prev_e) seq = seq * 100 + 10;
            if (done) begin
                ndone++;
                lat = cyc;
                timed_out = 0;
                break;
            end
            if (fault) begin
                saw_fault = 1;
                timed_out = 0;
                break;
            end
            if (prev_e && !eject_5 && !eject_10) begin
                inwait = 1;
                if (ack) begin
                    coin_drop = 1'b1;
                    refill_5 = rf;
                end
            end
            if (inwait) wcyc++;
            prev_e = eject_5 | eject_10;
            @(negedge clk);
        end
        coin_drop = 1'b0;
        refill_5 = 1'b0;
        chk("bound", 32'(timed_out), 32'd0);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_code", 32'(fault_code), 32'd0);
        chk("rst_ej", 32'({eject_5, eject_10}), 32'd0);
        chk("rst_s5", 32'(stock_5), 32'd4);
        chk("rst_s10", 32'(stock_10), 32'd2);
        rst = 1'b1;

        // single 5 coin
        pay(2'b01, 1, 0);
        chk("t1_n5", 32'(n5), 32'd2);
        chk("t1_n10", 32'(n10), 32'd0);
        chk("t1_lat", 32'(lat), 32'd6);
        chk("t1_s5", 32'(stock_5), 32'd3);
        chk("t1_s10", 32'(stock_10), 32'd2);

        // 15 = 10 + 5
        do_reset();
        pay(2'b11, 1, 0);
        chk("t2_seq", 32'(seq), 32'd1005);
        chk("t2_n10", 32'(n10), 32'd2);
        chk("t2_n5", 32'(n5), 32'd2);
        chk("t2_ovl", 32'(overlap), 32'd0);
        chk("t2_s10", 32'(stock_10), 32'd1);
        chk("t2_s5", 32'(stock_5), 32'd3);
        @(negedge clk);
        chk("t2_done1", 32'(done), 32'd0);
        chk("t2_idle", 32'(busy), 32'd0);

        // empty 10 tube: 10 paid as 5+5
        do_reset();
        pay(2'b10, 1, 0);
        pay(2'b10, 1, 0);
        chk("t3_s10", 32'(stock_10), 32'd0);
        pay(2'b10, 1, 0);
        chk("t3_seq", 32'(seq), 32'd505);
        chk("t3_s5", 32'(stock_5), 32'd2);
        chk("t3_flt", 32'(saw_fault), 32'd0);

        // jam timeout
        do_reset();
        pay(2'b01, 0, 0);
        chk("t4_flt", 32'(saw_fault), 32'd1);
        chk("t4_n5", 32'(n5), 32'd2);
        chk("t4_wait", 32'(wcyc), 32'd8);
        chk("t4_code", 32'(fault_code), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_s5", 32'(stock_5), 32'd4);
        pulse_clr();
        chk("t4_clr_busy", 32'(busy), 32'd0);
        chk("t4_clr_flt", 32'(fault), 32'd0);
        chk("t4_clr_code", 32'(fault_code), 32'd0);

        // insufficient stock
        do_reset();
        pay(2'b11, 1, 0);
        pay(2'b11, 1, 0);
        pay(2'b10, 1, 0);
        chk("t5_s5", 32'(stock_5), 32'd0);
        chk("t5_s10", 32'(stock_10), 32'd0);
        pay(2'b01, 1, 0);
        chk("t5_noej", 32'(n5 + n10), 32'd0);
        chk("t5_flt", 32'(saw_fault), 32'd1);
        chk("t5_code", 32'(fault_code), 32'd2);
        @(negedge clk);
        refill_5 = 1'b1;
        @(negedge clk);
        refill_5 = 1'b0;
        chk("t5_refill", 32'(stock_5), 32'd1);
        pulse_clr();
        chk("t5_clr_busy", 32'(busy), 32'd0);
        pay(2'b01, 1, 0);
        chk("t5_done", 32'(ndone), 32'd1);
        chk("t5_s5b", 32'(stock_5), 32'd0);

        // refill and consume in the same cycle
        do_reset();
        pay(2'b01, 1, 1);
        chk("t6_done", 32'(ndone), 32'd1);
        chk("t6_s5", 32'(stock_5), 32'd4);

        // refill saturation
        @(negedge clk);
        refill_10 = 1'b1;
        repeat (20) @(negedge clk);
        refill_10 = 1'b0;
        chk("t7_sat", 32'(stock_10), 32'd15);

        // zero change request
        pay(2'b00, 1, 0);
        chk("t8_lat", 32'(lat), 32'd1);
        chk("t8_busy", 32'(busy), 32'd0);

        // reset during an eject strobe
        do_reset();
        pay(2'b01, 1, 0);
        chk("t9_pre", 32'(stock_5), 32'd3);
        @(negedge clk);
        change = 2'b01;
        change_vld = 1'b1;
        @(negedge clk);
        change_vld = 1'b0;
        change = 2'b00;
        @(negedge clk);
        chk("t9_ej_on", 32'(eject_5), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t9_ej_off", 32'(eject_5), 32'd0);
        chk("t9_busy", 32'(busy), 32'd0);
        chk("t9_s5", 32'(stock_5), 32'd4);
        chk("t9_s10", 32'(stock_10), 32'd2);
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
